// File: rtl/led_pkg.sv
// -----------------------------------------------------------------------------
// led_pkg
// Shared definitions for the LED mode controller: mode encodings, breath step
// sizes, the output bundle driven per mode, and helpers for mode sequencing and
// output decoding.
// -----------------------------------------------------------------------------
package led_pkg;

  // Mode encodings; 3'd5..3'd7 are illegal and recover to MODE_OFF.
  typedef enum logic [2:0] {
    MODE_OFF         = 3'd0,
    MODE_ON          = 3'd1,
    MODE_BREATH_SLOW = 3'd2,
    MODE_BREATH_FAST = 3'd3,
    MODE_BLINK       = 3'd4
  } mode_e;

  // Breath threshold increments per PWM period.
  localparam logic [15:0] STEP_SLOW = 16'd25;
  localparam logic [15:0] STEP_FAST = 16'd100;

  // Mode-dependent LED outputs, registered together with the mode.
  typedef struct packed {
    logic        ovr_en;
    logic        ovr_val;
    logic        breath_en;
    logic [15:0] breath_step;
  } led_out_t;

  // Next mode in the short-press cycle; anything illegal goes to OFF.
  function automatic mode_e next_mode(input mode_e cur);
    mode_e nxt;
    case (cur)
      MODE_OFF:         nxt = MODE_ON;
      MODE_ON:          nxt = MODE_BREATH_SLOW;
      MODE_BREATH_SLOW: nxt = MODE_BREATH_FAST;
      MODE_BREATH_FAST: nxt = MODE_BLINK;
      MODE_BLINK:       nxt = MODE_OFF;
      default:          nxt = MODE_OFF;
    endcase
    return nxt;
  endfunction

  // Output bundle for a given mode; blink_val is only used in BLINK.
  function automatic led_out_t mode_outputs(input mode_e m, input logic blink_val);
    led_out_t o;
    o.ovr_en      = 1'b1;
    o.ovr_val     = 1'b0;
    o.breath_en   = 1'b0;
    o.breath_step = 16'd0;
    case (m)
      MODE_OFF: begin
        o.ovr_en  = 1'b1;
        o.ovr_val = 1'b0;
      end
      MODE_ON: begin
        o.ovr_en  = 1'b1;
        o.ovr_val = 1'b1;
      end
      MODE_BREATH_SLOW: begin
        o.ovr_en      = 1'b0;
        o.breath_en   = 1'b1;
        o.breath_step = STEP_SLOW;
      end
      MODE_BREATH_FAST: begin
        o.ovr_en      = 1'b0;
        o.breath_en   = 1'b1;
        o.breath_step = STEP_FAST;
      end
      MODE_BLINK: begin
        o.ovr_en  = 1'b1;
        o.ovr_val = blink_val;
      end
      default: begin
        o.ovr_en  = 1'b1;
        o.ovr_val = 1'b0;
      end
    endcase
    return o;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// -----------------------------------------------------------------------------
// key_debounce
// Two-flop synchroniser followed by a debounce counter for an active-low,
// bouncing push-button. The debounced level only follows the synchronised
// level once it has differed for DEBOUNCE_CYC consecutive cycles.
//
// Ports:
//   clk       in   system clock, rising edge
//   rst_n     in   asynchronous active-low reset
//   key_n     in   raw button, active-low, asynchronous to clk
//   level_o   out  debounced key level (1 = released)
//   press_o   out  one-cycle pulse on a debounced 1->0 transition
//   release_o out  one-cycle pulse on a debounced 0->1 transition
// -----------------------------------------------------------------------------
module key_debounce
  import led_pkg::*;
#(
  parameter int DEBOUNCE_CYC = 1_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_n,
  output logic level_o,
  output logic press_o,
  output logic release_o
);

  localparam int                 CNT_W    = $clog2(DEBOUNCE_CYC + 1);
  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);

  logic             sync1_q,   sync1_d;
  logic             sync2_q,   sync2_d;
  logic             level_q,   level_d;
  logic             press_q,   press_d;
  logic             release_q, release_d;
  logic [CNT_W-1:0] cnt_q,     cnt_d;

  // Next-state: synchroniser shift and debounce counting/acceptance.
  always_comb begin
    sync1_d   = key_n;
    sync2_d   = sync1_q;
    level_d   = level_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    cnt_d     = {CNT_W{1'b0}};
    if (sync2_q != level_q) begin
      // The edge that would make the count reach DEBOUNCE_CYC accepts the level.
      if (cnt_q == CNT_LAST) begin
        level_d   = sync2_q;
        cnt_d     = {CNT_W{1'b0}};
        press_d   = ~sync2_q;
        release_d = sync2_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1'b1);
      end
    end else begin
      // Any reversion to the accepted level restarts the count.
      cnt_d = {CNT_W{1'b0}};
    end
  end

  // State registers; the key is treated as released during reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q   <= 1'b1;
      sync2_q   <= 1'b1;
      level_q   <= 1'b1;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      cnt_q     <= {CNT_W{1'b0}};
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
      cnt_q     <= cnt_d;
    end
  end

  assign level_o   = level_q;
  assign press_o   = press_q;
  assign release_o = release_q;

endmodule

// File: rtl/led_mode_ctrl.sv
// -----------------------------------------------------------------------------
// led_mode_ctrl
// Single-button LED mode controller. A short press (released before LONG_CYC
// held cycles) advances OFF -> ON -> BREATH_SLOW -> BREATH_FAST -> BLINK -> OFF.
// A long press forces OFF the moment the hold count reaches LONG_CYC and its
// release is ignored. All outputs are registered and update together.
//
// Ports:
//   clk         in   system clock, rising edge
//   rst_n       in   asynchronous active-low reset
//   key_n       in   raw button, active-low, bouncing
//   led_mode    out  current mode encoding
//   breath_en   out  enable for the downstream PWM breath stage
//   breath_step out  breath threshold increment per PWM period
//   ovr_en      out  LED pin driven by ovr_val instead of the breath stage
//   ovr_val     out  LED level while ovr_en is set
//   mode_chg    out  one-cycle pulse on every mode change
// -----------------------------------------------------------------------------
module led_mode_ctrl
  import led_pkg::*;
#(
  parameter int DEBOUNCE_CYC = 1_000_000,
  parameter int LONG_CYC     = 50_000_000,
  parameter int BLINK_CYC    = 12_500_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        key_n,
  output logic [2:0]  led_mode,
  output logic        breath_en,
  output logic [15:0] breath_step,
  output logic        ovr_en,
  output logic        ovr_val,
  output logic        mode_chg
);

  localparam int                 HOLD_W     = $clog2(LONG_CYC + 1);
  localparam logic [HOLD_W-1:0]  HOLD_MAX   = HOLD_W'(LONG_CYC);
  localparam int                 BLINK_W    = $clog2(BLINK_CYC + 1);
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_CYC - 1);

  logic key_level_s;
  logic key_press_s;
  logic key_release_s;

  key_debounce #(
    .DEBOUNCE_CYC (DEBOUNCE_CYC)
  ) u_key (
    .clk       (clk),
    .rst_n     (rst_n),
    .key_n     (key_n),
    .level_o   (key_level_s),
    .press_o   (key_press_s),
    .release_o (key_release_s)
  );

  mode_e              mode_q,        mode_d;
  logic               active_q,      active_d;
  logic [HOLD_W-1:0]  hold_q,        hold_d;
  logic [BLINK_W-1:0] blink_cnt_q,   blink_cnt_d;
  logic               blink_val_q,   blink_val_d;
  logic               ovr_en_q,      ovr_en_d;
  logic               ovr_val_q,     ovr_val_d;
  logic               breath_en_q,   breath_en_d;
  logic [15:0]        breath_step_q, breath_step_d;
  logic               mode_chg_q,    mode_chg_d;

  mode_e              mode_base_s;
  logic [HOLD_W-1:0]  hold_inc_s;
  led_out_t           out_s;

  // Next-state: mode sequencing, hold counting, blink timing, output decode.
  always_comb begin
    // Illegal encodings fall back to OFF even without key activity.
    case (mode_q)
      MODE_OFF, MODE_ON, MODE_BREATH_SLOW, MODE_BREATH_FAST, MODE_BLINK:
        mode_base_s = mode_q;
      default:
        mode_base_s = MODE_OFF;
    endcase

    mode_d     = mode_base_s;
    active_d   = active_q;
    hold_d     = hold_q;
    hold_inc_s = hold_q + HOLD_W'(1'b1);

    if (key_press_s) begin
      active_d = 1'b1;
      hold_d   = {HOLD_W{1'b0}};
    end else if (key_release_s) begin
      active_d = 1'b0;
      hold_d   = {HOLD_W{1'b0}};
      // A release after a saturated hold belongs to a long press: ignore it.
      if (active_q && (hold_q < HOLD_MAX)) begin
        mode_d = next_mode(mode_q);
      end else begin
        mode_d = mode_base_s;
      end
    end else if (active_q && !key_level_s && (hold_q < HOLD_MAX)) begin
      hold_d = hold_inc_s;
      // Force OFF on the very edge the count saturates.
      if (hold_inc_s == HOLD_MAX) begin
        mode_d = MODE_OFF;
      end else begin
        mode_d = mode_base_s;
      end
    end else begin
      hold_d = hold_q;
    end

    // Blink phase restarts high with a cleared counter on every BLINK entry.
    if (mode_d != MODE_BLINK) begin
      blink_cnt_d = {BLINK_W{1'b0}};
      blink_val_d = 1'b1;
    end else if (mode_q != MODE_BLINK) begin
      blink_cnt_d = {BLINK_W{1'b0}};
      blink_val_d = 1'b1;
    end else if (blink_cnt_q == BLINK_LAST) begin
      blink_cnt_d = {BLINK_W{1'b0}};
      blink_val_d = ~blink_val_q;
    end else begin
      blink_cnt_d = blink_cnt_q + BLINK_W'(1'b1);
      blink_val_d = blink_val_q;
    end

    // Outputs are decoded from the next mode so they register alongside it.
    out_s         = mode_outputs(mode_d, blink_val_d);
    ovr_en_d      = out_s.ovr_en;
    ovr_val_d     = out_s.ovr_val;
    breath_en_d   = out_s.breath_en;
    breath_step_d = out_s.breath_step;
    mode_chg_d    = (mode_d != mode_q);
  end

  // Mode FSM and registered outputs; reset abandons any press in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q        <= MODE_OFF;
      active_q      <= 1'b0;
      hold_q        <= {HOLD_W{1'b0}};
      blink_cnt_q   <= {BLINK_W{1'b0}};
      blink_val_q   <= 1'b1;
      ovr_en_q      <= 1'b1;
      ovr_val_q     <= 1'b0;
      breath_en_q   <= 1'b0;
      breath_step_q <= 16'd0;
      mode_chg_q    <= 1'b0;
    end else begin
      mode_q        <= mode_d;
      active_q      <= active_d;
      hold_q        <= hold_d;
      blink_cnt_q   <= blink_cnt_d;
      blink_val_q   <= blink_val_d;
      ovr_en_q      <= ovr_en_d;
      ovr_val_q     <= ovr_val_d;
      breath_en_q   <= breath_en_d;
      breath_step_q <= breath_step_d;
      mode_chg_q    <= mode_chg_d;
    end
  end

  assign led_mode    = mode_q;
  assign breath_en   = breath_en_q;
  assign breath_step = breath_step_q;
  assign ovr_en      = ovr_en_q;
  assign ovr_val     = ovr_val_q;
  assign mode_chg    = mode_chg_q;

endmodule

// File: tb/tb_led_mode_ctrl.sv
// Testbench for led_mode_ctrl with small timing parameters.
module tb_led_mode_ctrl;

  localparam int DEB   = 8;
  localparam int LONG  = 64;
  localparam int BLINK = 4;

  logic        clk;
  logic        rst_n;
  logic        key_n;
  logic [2:0]  led_mode;
  logic        breath_en;
  logic [15:0] breath_step;
  logic        ovr_en;
  logic        ovr_val;
  logic        mode_chg;

  led_mode_ctrl #(
    .DEBOUNCE_CYC (DEB),
    .LONG_CYC     (LONG),
    .BLINK_CYC    (BLINK)
  ) u_dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .key_n       (key_n),
    .led_mode    (led_mode),
    .breath_en   (breath_en),
    .breath_step (breath_step),
    .ovr_en      (ovr_en),
    .ovr_val     (ovr_val),
    .mode_chg    (mode_chg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0]  mode;
    logic [15:0] step;
    logic        ben;
    logic        oen;
    logic        oval;
  } exp_t;

  exp_t sb[$];
  int   pass_cnt = 0;
  int   chk_cnt  = 0;
  int   chg_cnt  = 0;
  int   cur_mode = 0;
  logic prev_chg = 1'b0;

  // Reference outputs for a freshly entered mode.
  function automatic exp_t model(input int m);
    exp_t e;
    e.mode = 3'(m);
    e.step = 16'd0;
    e.ben  = 1'b0;
    e.oen  = 1'b1;
    e.oval = 1'b0;
    case (m)
      1: e.oval = 1'b1;
      2: begin e.oen = 1'b0; e.ben = 1'b1; e.step = 16'd25; end
      3: begin e.oen = 1'b0; e.ben = 1'b1; e.step = 16'd100; end
      4: e.oval = 1'b1;
      default: e.oval = 1'b0;
    endcase
    return e;
  endfunction

  function automatic int succ(input int m);
    return (m == 4) ? 0 : m + 1;
  endfunction

  // Scoreboard monitor: every mode_chg pulse pops one expected mode record.
  always @(negedge clk) begin
    exp_t obs;
    exp_t e;
    if (mode_chg === 1'b1) begin
      chg_cnt++;
      obs = {led_mode, breath_step, breath_en, ovr_en, ovr_val};
      chk_cnt++;
      if (sb.size() == 0) begin
        $display("FAIL unexpected_mode_chg: got mode=%0d, required no change", led_mode);
      end else begin
        e = sb.pop_front();
        if (obs !== e)
          $display("FAIL mode_outputs: got mode=%0d step=%0d ben=%b oen=%b oval=%b, required mode=%0d step=%0d ben=%b oen=%b oval=%b",
                   obs.mode, obs.step, obs.ben, obs.oen, obs.oval, e.mode, e.step, e.ben, e.oen, e.oval);
        else
          pass_cnt++;
      end
      chk_cnt++;
      if (prev_chg !== 1'b0)
        $display("FAIL mode_chg_width: got pulse of 2+ cycles, required 1");
      else
        pass_cnt++;
    end
    prev_chg = mode_chg;
  end

  // Short press of 20 cycles; returns cycles from release to mode_chg.
  task automatic short_press(output int lat);
    cur_mode = succ(cur_mode);
    sb.push_back(model(cur_mode));
    key_n = 1'b0;
    repeat (20) @(negedge clk);
    key_n = 1'b1;
    lat = 0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (mode_chg === 1'b1 && lat == 0) lat = c;
    end
  endtask

  task automatic check_reset_vals(input string tag);
    chk_cnt++;
    if ({led_mode, ovr_en, ovr_val, breath_en, breath_step, mode_chg} !== {3'd0, 1'b1, 1'b0, 1'b0, 16'd0, 1'b0})
      $display("FAIL %s: got mode=%0d oen=%b oval=%b ben=%b step=%0d chg=%b, required 0 1 0 0 0 0",
               tag, led_mode, ovr_en, ovr_val, breath_en, breath_step, mode_chg);
    else
      pass_cnt++;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    key_n = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_vals("reset_values");
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check_reset_vals("after_reset_idle");
  endtask

  task automatic test_short_presses;
    int lat;
    int c0;
    c0 = chg_cnt;
    for (int i = 0; i < 5; i++) begin
      short_press(lat);
      chk_cnt++;
      if (lat !== 11)
        $display("FAIL short_press_latency[%0d]: got %0d cycles, required 11", i, lat);
      else
        pass_cnt++;
    end
    chk_cnt++;
    if (chg_cnt - c0 !== 5)
      $display("FAIL short_press_pulses: got %0d, required 5", chg_cnt - c0);
    else
      pass_cnt++;
  endtask

  task automatic test_bounce;
    int presses;
    int lat;
    int dummy;
    presses = 0;
    lat = 0;
    for (int c = 0; c < 30; c++) begin
      key_n = (((c / 3) % 2) == 0) ? 1'b0 : 1'b1;
      @(negedge clk);
      if (u_dut.key_press_s === 1'b1) presses++;
    end
    key_n = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (u_dut.key_press_s === 1'b1) begin
        presses++;
        if (lat == 0) lat = c;
      end
    end
    chk_cnt++;
    if (presses !== 1)
      $display("FAIL bounce_press_count: got %0d, required 1", presses);
    else
      pass_cnt++;
    chk_cnt++;
    if (lat !== 10)
      $display("FAIL bounce_press_latency: got %0d, required 10", lat);
    else
      pass_cnt++;
    // Release ends this press as a short one: OFF -> ON.
    cur_mode = succ(cur_mode);
    sb.push_back(model(cur_mode));
    key_n = 1'b1;
    repeat (40) @(negedge clk);
    dummy = 0;
    chk_cnt++;
    if (led_mode !== 3'd1)
      $display("FAIL bounce_mode: got %0d, required 1", led_mode);
    else
      pass_cnt++;
  endtask

  task automatic test_long_press_fast;
    int lat;
    int c0;
    short_press(lat);
    short_press(lat);
    chk_cnt++;
    if (led_mode !== 3'd3)
      $display("FAIL reach_breath_fast: got %0d, required 3", led_mode);
    else
      pass_cnt++;
    cur_mode = 0;
    sb.push_back(model(0));
    key_n = 1'b0;
    lat = 0;
    for (int c = 1; c <= 100; c++) begin
      @(negedge clk);
      if (mode_chg === 1'b1 && lat == 0) lat = c;
    end
    chk_cnt++;
    if (lat !== 75)
      $display("FAIL long_press_latency: got %0d cycles, required 75", lat);
    else
      pass_cnt++;
    c0 = chg_cnt;
    key_n = 1'b1;
    repeat (40) @(negedge clk);
    chk_cnt++;
    if (chg_cnt - c0 !== 0 || led_mode !== 3'd0)
      $display("FAIL long_release_ignored: got %0d pulses mode=%0d, required 0 pulses mode=0", chg_cnt - c0, led_mode);
    else
      pass_cnt++;
  endtask

  task automatic test_blink;
    int lat;
    int waited;
    logic [11:0] pattern;
    pattern = 12'b1111_0000_1111;
    for (int i = 0; i < 3; i++) short_press(lat);
    cur_mode = succ(cur_mode);
    sb.push_back(model(cur_mode));
    key_n = 1'b0;
    repeat (20) @(negedge clk);
    key_n = 1'b1;
    waited = 0;
    while (mode_chg !== 1'b1 && waited < 40) begin
      @(negedge clk);
      waited++;
    end
    chk_cnt++;
    if (mode_chg !== 1'b1)
      $display("FAIL blink_entry_timeout: got no mode_chg in 40 cycles, required entry");
    else
      pass_cnt++;
    for (int k = 0; k < 12; k++) begin
      chk_cnt++;
      if (ovr_val !== pattern[11-k] || ovr_en !== 1'b1)
        $display("FAIL blink_pattern[%0d]: got oval=%b oen=%b, required oval=%b oen=1", k, ovr_val, ovr_en, pattern[11-k]);
      else
        pass_cnt++;
      @(negedge clk);
    end
    repeat (10) @(negedge clk);
    short_press(lat);
  endtask

  task automatic test_reset_mid_press;
    int lat;
    int c0;
    short_press(lat);
    key_n = 1'b0;
    repeat (15) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check_reset_vals("mid_press_reset_values");
    repeat (2) @(negedge clk);
    c0 = chg_cnt;
    rst_n = 1'b1;
    cur_mode = 0;
    repeat (2) @(negedge clk);
    key_n = 1'b1;
    repeat (40) @(negedge clk);
    chk_cnt++;
    if (chg_cnt - c0 !== 0 || led_mode !== 3'd0)
      $display("FAIL mid_press_no_change: got %0d pulses mode=%0d, required 0 pulses mode=0", chg_cnt - c0, led_mode);
    else
      pass_cnt++;
  endtask

  task automatic test_long_press_off;
    int c0;
    c0 = chg_cnt;
    key_n = 1'b0;
    repeat (100) @(negedge clk);
    chk_cnt++;
    if (chg_cnt - c0 !== 0 || led_mode !== 3'd0)
      $display("FAIL long_press_off_hold: got %0d pulses mode=%0d, required 0 pulses mode=0", chg_cnt - c0, led_mode);
    else
      pass_cnt++;
    key_n = 1'b1;
    repeat (40) @(negedge clk);
    chk_cnt++;
    if (chg_cnt - c0 !== 0 || led_mode !== 3'd0)
      $display("FAIL long_press_off_release: got %0d pulses mode=%0d, required 0 pulses mode=0", chg_cnt - c0, led_mode);
    else
      pass_cnt++;
  endtask

  initial begin
    rst_n = 1'b0;
    key_n = 1'b1;
    test_reset();
    test_short_presses();
    test_bounce();
    test_long_press_fast();
    test_blink();
    test_reset_mid_press();
    test_long_press_off();
    chk_cnt++;
    if (sb.size() !== 0)
      $display("FAIL scoreboard_drain: got %0d pending mode changes, required 0", sb.size());
    else
      pass_cnt++;
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
